rom_arbiter: RTL and testbench
==============================

# rom_arbiter

Sequencer and arbiter that shares the single-port fake memory (`rom`) between three requesters: instruction-fetch read, load/store read and load/store write. It serialises all accesses, so memory read-enable and write-enable are never both high at a clock edge. It issues each access as a one-cycle enable pulse and waits a fixed memory latency. It then returns data and a one-cycle done pulse to the winning requester, and sits between the fetch/LSU units and `rom`.

## Interface
- `MEM_LAT`, default 1: number of WAIT cycles after the ISSUE cycle before memory read data is captured; legal range 1..15.
- `clk`  in  1  system clock; all state changes on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_rd`  rom_inf.rom_read  -  fetch read requester.
  - Inputs: `en`, `addr[31:0]`, `byte_num[2:0]`.
  - Outputs: `data[31:0]`, `done`.
- `ls_rd`  rom_inf.rom_read  -  load read requester; same signals as `if_rd`.
- `ls_wr`  rom_inf.rom_write  -  store requester.
  - Inputs: `en`, `addr[31:0]`, `data[31:0]`, `byte_num[2:0]`.
  - Output: `done`.
- `mem_rd`  rom_inf.unit_read  -  memory read port.
  - Outputs: `en`, `addr`, `byte_num`.
  - Inputs: `data`, `done`; `done` is ignored.
- `mem_wr`  rom_inf.unit_write  -  memory write port.
  - Outputs: `en`, `addr`, `data`, `byte_num`.
  - Input: `done`; ignored.
- `err`  out  1  one-cycle pulse when a request with illegal `byte_num` is completed.

## Operation
- Requester protocol:
  - The requester raises `en` and holds `addr`/`data`/`byte_num` stable until it samples `done`=1.
  - It drops `en` in the cycle after `done`.
  - `done` is a single-cycle pulse.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: if any `en` is high, grant one requester, latch its addr/data/byte_num/kind into the request register, then go to ISSUE.
  - ISSUE (1 cycle): drive `mem_rd.en`=1 for a read or `mem_wr.en`=1 for a write, plus addr/byte_num (and data for writes) from the request register. Load the wait counter with `MEM_LAT`, then go to WAIT.
  - WAIT: decrement the counter each cycle. At the edge where the counter reaches 0, capture `mem_rd.data` for reads, then go to DONE.
  - DONE (1 cycle): drive `done`=1 to the granted requester only, with its `data` output valid. Go to IDLE. Requests are not evaluated in DONE.
- Arbitration is round-robin over the order if_rd -> ls_rd -> ls_wr.
  - The pointer moves to the requester after the last grant.
  - After reset, `if_rd` has highest priority.
- Read data formatting:
  - `byte_num`=1: `{24'b0, mem[7:0]}`.
  - `byte_num`=2: `{16'b0, mem[15:0]}`.
  - `byte_num`=4: full 32 bits.
  - Upper memory bits are never forwarded.
- Illegal `byte_num` (not 1, 2 or 4):
  - No memory enable is driven in ISSUE; the FSM still passes through WAIT.
  - DONE returns `data`=0, `done`=1 and pulses `err` in the same cycle.
- Requester `data` outputs hold their last returned value until the next completion to that requester.
- Memory `addr`/`data`/`byte_num` hold the request-register contents in all states. Enables are high only in ISSUE.

## Timing
- Reset values (immediate, asynchronous): state IDLE, RR pointer to `if_rd`, counter 0, all `en`/`done`/`err` 0, all data/addr/byte_num outputs 0.
- Latency with `MEM_LAT`=1: requester `en` sampled at edge E0; ISSUE in cycle E0..E1; WAIT in E1..E2 with data captured at E2; `done` high in E2..E3. That is `MEM_LAT`+2 cycles from sampling to the done pulse.
- Back-to-back throughput: one access per `MEM_LAT`+3 cycles, since IDLE always costs one cycle.
- Simultaneous requests: exactly one is granted per pass through IDLE. Losers keep `en` high and are served in later passes; no request waits more than two other grants.
- `en` dropped mid-transaction: the transaction still completes and `done` still pulses.
- Reset asserted mid-transaction: the access is abandoned and no `done` is issued. A memory write that was already sampled is not undone.
- `mem_rd.en` and `mem_wr.en` are never both 1 in any cycle.

## Test plan
- Single fetch:
  - Preload mem[0x10..0x13] = 11 22 33 44.
  - `if_rd` reads 4 bytes at 0x10 -> `done` 3 cycles after the sampling edge, `data`=0x44332211, one `mem_rd.en` pulse.
- Store then load:
  - `ls_wr` writes 2 bytes, data 0xABCD, at 0x20.
  - Then `ls_rd` reads 1 byte at 0x21 -> `data`=0x000000AB.
  - `mem_wr.en` and `mem_rd.en` are never both high.
- Three simultaneous requests held high from reset -> grant order if_rd, ls_rd, ls_wr, if_rd, and so on. `done` pulses are spaced 4 cycles apart.
- Illegal `byte_num`=3 on `ls_rd` -> no memory enable is driven; `done`=1, `data`=0 and `err`=1 in the same cycle.
- Async reset low during WAIT -> all outputs 0 immediately, no `done`. After release, a pending `if_rd` request is served normally.
- `MEM_LAT`=3 build: fetch -> `done` 5 cycles after the sampling edge with correct data.

Source files
------------

// File: rtl/rom_arbiter_if.sv
// Request/response bundle shared by the fetch/LSU requesters and the fake memory.
// Requester-facing modports are seen from the arbiter; unit modports drive the memory.
interface rom_inf;
    logic        en;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  byte_num;
    logic        done;

    modport rom_read   (input en, addr, byte_num, output data, done);
    modport rom_write  (input en, addr, data, byte_num, output done);
    modport unit_read  (output en, addr, byte_num, input data, done);
    modport unit_write (output en, addr, data, byte_num, input done);
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin sequencer sharing one single-port memory between fetch read,
// load read and store write; one access in flight, fixed read latency.
module rom_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    rom_inf.rom_read   if_rd,
    rom_inf.rom_read   ls_rd,
    rom_inf.rom_write  ls_wr,
    rom_inf.unit_read  mem_rd,
    rom_inf.unit_write mem_wr,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam logic [1:0] G_IF = 2'd0, G_LR = 2'd1, G_LW = 2'd2;

    state_t      state, state_nx;
    logic [1:0]  ptr, gnt, pick, idx;
    logic [2:0]  req, sum;
    logic        any, legal;
    logic [3:0]  cnt;
    logic [31:0] r_addr, r_data, if_data, ls_data, fmt;
    logic [2:0]  r_bn;
    logic        unused_done;

    assign req         = {ls_wr.en, ls_rd.en, if_rd.en};
    assign unused_done = mem_rd.done ^ mem_wr.done;

    // Scan from the highest offset down so the requester nearest the pointer wins.
    always_comb begin
        any  = 1'b0;
        pick = ptr;
        sum  = '0;
        idx  = '0;
        for (int i = 2; i >= 0; i--) begin
            sum = {1'b0, ptr} + 3'(i);
            if (sum >= 3'd3) sum = sum - 3'd3;
            idx = sum[1:0];
            if (req[idx]) begin
                any  = 1'b1;
                pick = idx;
            end
        end
    end

    assign legal = (r_bn == 3'd1) || (r_bn == 3'd2) || (r_bn == 3'd4);

    always_comb begin
        case (r_bn)
            3'd1:    fmt = {24'b0, mem_rd.data[7:0]};
            3'd2:    fmt = {16'b0, mem_rd.data[15:0]};
            3'd4:    fmt = mem_rd.data;
            default: fmt = '0;
        endcase
    end

    always_comb begin
        state_nx   = state;
        mem_rd.en  = 1'b0;
        mem_wr.en  = 1'b0;
        if_rd.done = 1'b0;
        ls_rd.done = 1'b0;
        ls_wr.done = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE:  if (any) state_nx = ISSUE;
            ISSUE: begin
                mem_rd.en = legal && (gnt != G_LW);
                mem_wr.en = legal && (gnt == G_LW);
                state_nx  = WAIT;
            end
            WAIT:  if (cnt <= 4'd1) state_nx = DONE;
            DONE: begin
                if_rd.done = (gnt == G_IF);
                ls_rd.done = (gnt == G_LR);
                ls_wr.done = (gnt == G_LW);
                err        = !legal;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ptr     <= G_IF;
            gnt     <= G_IF;
            cnt     <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_bn    <= '0;
            if_data <= '0;
            ls_data <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (any) begin
                    gnt <= pick;
                    ptr <= (pick == G_LW) ? G_IF : pick + 2'd1;
                    case (pick)
                        G_IF: begin
                            r_addr <= if_rd.addr;
                            r_bn   <= if_rd.byte_num;
                        end
                        G_LR: begin
                            r_addr <= ls_rd.addr;
                            r_bn   <= ls_rd.byte_num;
                        end
                        default: begin
                            r_addr <= ls_wr.addr;
                            r_data <= ls_wr.data;
                            r_bn   <= ls_wr.byte_num;
                        end
                    endcase
                end
                ISSUE: cnt <= 4'(MEM_LAT);
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    // fmt is zero for illegal sizes, so the error reply carries data 0.
                    if (cnt <= 4'd1) begin
                        if (gnt == G_IF)      if_data <= fmt;
                        else if (gnt == G_LR) ls_data <= fmt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_rd.data      = if_data;
    assign ls_rd.data      = ls_data;
    assign mem_rd.addr     = r_addr;
    assign mem_rd.byte_num = r_bn;
    assign mem_wr.addr     = r_addr;
    assign mem_wr.data     = r_data;
    assign mem_wr.byte_num = r_bn;
endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: byte-array memory, directed scenarios and randomized
// rounds checked against a round-robin / byte-array reference model.
module tb_rom_arbiter;
    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err, err3;
    always #5 clk = ~clk;

    rom_inf if_i(), lr_i(), lw_i(), mr_i(), mw_i();
    rom_inf if2(), lr2(), lw2(), mr2(), mw2();

    rom_arbiter #(.MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .if_rd(if_i), .ls_rd(lr_i), .ls_wr(lw_i),
        .mem_rd(mr_i), .mem_wr(mw_i), .err(err));
    rom_arbiter #(.MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .if_rd(if2), .ls_rd(lr2), .ls_wr(lw2),
        .mem_rd(mr2), .mem_wr(mw2), .err(err3));

    // ---- memory model ----
    logic [7:0]  mem [256];
    logic [31:0] rdata = '0, rdata2 = '0;
    logic        bd_we = 1'b0;
    logic [7:0]  bd_addr = '0, bd_val = '0;

    function automatic logic [31:0] rd32(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
    endfunction

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_val;
        if (mw_i.en)
            for (int k = 0; k < 4; k++)
                if (k < int'(mw_i.byte_num)) mem[mw_i.addr[7:0] + 8'(k)] <= mw_i.data[8*k +: 8];
        if (mr_i.en) rdata  <= rd32(mr_i.addr);
        if (mr2.en)  rdata2 <= rd32(mr2.addr);
    end

    assign mr_i.data = rdata;
    assign mr2.data  = rdata2;
    assign mr_i.done = 1'b0;
    assign mw_i.done = 1'b0;
    assign mr2.done  = 1'b0;
    assign mw2.done  = 1'b0;

    // ---- reference model ----
    logic [7:0]  ref_mem [256];
    int          ptr = 0;
    bit          pend [3];
    logic [31:0] exp_d [3];
    bit          exp_e [3];
    int          rd_pulses, wr_pulses;
    int          checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [2:0] bn);
        return (bn == 3'd1) || (bn == 3'd2) || (bn == 3'd4);
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a, input logic [2:0] bn);
        logic [31:0] v;
        v = '0;
        if (!is_legal(bn)) return '0;
        for (int k = 0; k < int'(bn); k++)
            v = v | (32'(ref_mem[8'(a + 32'(k))]) << (8 * k));
        return v;
    endfunction

    task automatic poke(input logic [7:0] a, input logic [7:0] v);
        bd_addr = a; bd_val = v; bd_we = 1'b1;
        ref_mem[a] = v;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic req(input int r, input logic [31:0] a, input logic [2:0] bn, input logic [31:0] wd);
        pend[r]  = 1'b1;
        exp_e[r] = !is_legal(bn);
        exp_d[r] = exp_read(a, bn);
        case (r)
            0: begin if_i.addr = a; if_i.byte_num = bn; if_i.en = 1'b1; end
            1: begin lr_i.addr = a; lr_i.byte_num = bn; lr_i.en = 1'b1; end
            default: begin
                lw_i.addr = a; lw_i.byte_num = bn; lw_i.data = wd; lw_i.en = 1'b1;
                if (is_legal(bn))
                    for (int k = 0; k < int'(bn); k++) ref_mem[8'(a + 32'(k))] = wd[8*k +: 8];
            end
        endcase
    endtask

    task automatic drop(input int r);
        pend[r] = 1'b0;
        case (r)
            0: if_i.en = 1'b0;
            1: lr_i.en = 1'b0;
            default: lw_i.en = 1'b0;
        endcase
    endtask

    // Serve all pending requests; expected completion order is the cyclic scan from ptr.
    task automatic run(input int lat_exp, input int budget);
        int q[$];
        int n, r;
        logic [2:0] dn;
        n = 0;
        rd_pulses = 0;
        wr_pulses = 0;
        for (int k = 0; k < 3; k++) if (pend[(ptr + k) % 3]) q.push_back((ptr + k) % 3);
        while (q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
            if (mr_i.en) rd_pulses++;
            if (mw_i.en) wr_pulses++;
            chk("en_excl", 32'(mr_i.en & mw_i.en), 0);
            dn = {lw_i.done, lr_i.done, if_i.done};
            if (dn != 3'b0) begin
                r = q.pop_front();
                chk("done_owner", 32'(dn), 32'(1 << r));
                chk("err_at_done", 32'(err), 32'(exp_e[r]));
                if (r == 0) chk("if_data", if_i.data, exp_d[0]);
                if (r == 1) chk("ls_data", lr_i.data, exp_d[1]);
                if (lat_exp > 0) chk("latency", n, lat_exp);
                ptr = (r + 1) % 3;
                @(posedge clk); #1;
                drop(r);
            end else begin
                chk("err_quiet", 32'(err), 0);
            end
        end
        chk("all_served", q.size(), 0);
    endtask

    initial begin
        int n, got, last_t, mask, wa;
        logic [2:0] dn, bn;
        logic [2:0] bn_tab [8];
        bit wrote;
        bn_tab = '{3'd1, 3'd2, 3'd4, 3'd4, 3'd2, 3'd1, 3'd3, 3'd0};

        {if_i.en, lr_i.en, lw_i.en, if2.en, lr2.en, lw2.en} = '0;
        {if_i.addr, lr_i.addr, lw_i.addr, lw_i.data} = '0;
        {if2.addr, lr2.addr, lw2.addr, lw2.data} = '0;
        {if_i.byte_num, lr_i.byte_num, lw_i.byte_num} = '0;
        {if2.byte_num, lr2.byte_num, lw2.byte_num} = '0;
        for (int i = 0; i < 3; i++) begin pend[i] = 0; exp_d[i] = '0; exp_e[i] = 0; end

        #1 rst = 1'b0;
        #1;
        chk("rst_if_done", 32'(if_i.done), 0);
        chk("rst_mr_en",   32'(mr_i.en), 0);
        chk("rst_mw_en",   32'(mw_i.en), 0);
        chk("rst_mr_addr", mr_i.addr, 0);
        chk("rst_mw_data", mw_i.data, 0);
        chk("rst_err",     32'(err), 0);
        chk("rst_if_data", if_i.data, 0);

        for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
        poke(8'h10, 8'h11); poke(8'h11, 8'h22); poke(8'h12, 8'h33); poke(8'h13, 8'h44);

        // All three held high out of reset: strict rotation, done every LAT+3 cycles.
        req(0, 32'h10, 3'd4, 0);
        req(1, 32'h11, 3'd1, 0);
        req(2, 32'h90, 3'd2, 32'h1234_5678);
        @(posedge clk); #1;
        rst = 1'b1;
        n = 0; got = 0; last_t = 0;
        while (got < 6 && n < 80) begin
            @(negedge clk);
            n++;
            chk("hold_excl", 32'(mr_i.en & mw_i.en), 0);
            dn = {lw_i.done, lr_i.done, if_i.done};
            if (dn != 3'b0) begin
                chk("rr_order", 32'(dn), 32'(1 << (got % 3)));
                if (got == 0) chk("first_lat", n, LAT + 3);
                else          chk("spacing", n - last_t, LAT + 3);
                if (got % 3 == 0) chk("hold_if_data", if_i.data, exp_d[0]);
                if (got % 3 == 1) chk("hold_ls_data", lr_i.data, exp_d[1]);
                last_t = n;
                got++;
            end
        end
        chk("rr_count", got, 6);
        @(posedge clk); #1;
        drop(0); drop(1); drop(2);
        ptr = 0;

        // Single fetch.
        req(0, 32'h10, 3'd4, 0);
        run(LAT + 3, 20);
        chk("fetch_val", if_i.data, 32'h4433_2211);
        chk("fetch_rd_pulses", rd_pulses, 1);
        chk("fetch_wr_pulses", wr_pulses, 0);

        // Store then load.
        req(2, 32'h20, 3'd2, 32'h0000_ABCD);
        run(LAT + 3, 20);
        chk("store_wr_pulses", wr_pulses, 1);
        req(1, 32'h21, 3'd1, 0);
        run(LAT + 3, 20);
        chk("load_val", lr_i.data, 32'h0000_00AB);

        // Illegal size: no memory access, error reply.
        req(1, 32'h30, 3'd3, 0);
        run(LAT + 3, 20);
        chk("illegal_rd_pulses", rd_pulses, 0);
        chk("illegal_wr_pulses", wr_pulses, 0);
        chk("illegal_data", lr_i.data, 0);

        // Reset during WAIT abandons the access; request stays pending.
        req(0, 32'h40, 3'd4, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_done",  32'(if_i.done), 0);
        chk("mid_rst_data",  if_i.data, 0);
        chk("mid_rst_ldata", lr_i.data, 0);
        chk("mid_rst_mr_en", 32'(mr_i.en), 0);
        chk("mid_rst_addr",  mr_i.addr, 0);
        chk("mid_rst_bn",    32'(mr_i.byte_num), 0);
        chk("mid_rst_err",   32'(err), 0);
        repeat (3) begin
            @(negedge clk);
            chk("in_rst_nodone", 32'(if_i.done), 0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        ptr = 0;
        run(LAT + 3, 20);

        // Randomized rounds: random subsets; reads low half, writes high half.
        for (int round = 0; round < 40; round++) begin
            mask  = $urandom_range(1, 7);
            wrote = 1'b0;
            wa    = 0;
            for (int r = 0; r < 3; r++) begin
                if (mask[r]) begin
                    bn = bn_tab[$urandom_range(0, 7)];
                    if (r == 2) begin
                        wa = 32'h80 + $urandom_range(0, 32'h7B);
                        req(2, 32'(wa), bn, $urandom);
                        wrote = is_legal(bn);
                    end else begin
                        req(r, 32'($urandom_range(0, 32'h7B)), bn, 0);
                    end
                end
            end
            run(0, 60);
            if (wrote) begin
                req(1, 32'(wa), 3'd4, 0);
                run(LAT + 3, 20);
            end
        end

        // Longer-latency build.
        if2.addr = 32'h10; if2.byte_num = 3'd4; if2.en = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if2.done && n < 20);
        chk("lat3_latency", n, 6);
        chk("lat3_data", if2.data, 32'h4433_2211);
        chk("lat3_err", 32'(err3), 0);
        @(posedge clk); #1;
        if2.en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
